// File: rtl/rggen_register_access_arbiter.sv
// Round-robin arbiter sharing one register-block request channel among HOSTS bus hosts.
// One access in flight at a time; request fields and host responses are registered.
module rggen_register_access_arbiter #(
  parameter int unsigned HOSTS         = 2,
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned BUS_WIDTH     = 32
)(
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [HOSTS-1:0]               i_host_valid,
  input  logic [HOSTS*2-1:0]             i_host_access,
  input  logic [HOSTS*ADDRESS_WIDTH-1:0] i_host_address,
  input  logic [HOSTS*BUS_WIDTH-1:0]     i_host_write_data,
  input  logic [HOSTS*BUS_WIDTH-1:0]     i_host_strobe,
  output logic [HOSTS-1:0]               o_host_ready,
  output logic [1:0]                     o_host_status,
  output logic [BUS_WIDTH-1:0]           o_host_read_data,
  output logic                           o_valid,
  output logic [1:0]                     o_access,
  output logic [ADDRESS_WIDTH-1:0]       o_address,
  output logic [BUS_WIDTH-1:0]           o_write_data,
  output logic [BUS_WIDTH-1:0]           o_strobe,
  input  logic                           i_ready,
  input  logic [1:0]                     i_status,
  input  logic [BUS_WIDTH-1:0]           i_read_data,
  output logic [HOSTS-1:0]               o_grant
);

  localparam int unsigned HOST_INDEX_WIDTH = (HOSTS > 1) ? $clog2(HOSTS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_e;

  state_e                      state_q;
  state_e                      state_d;
  logic [HOST_INDEX_WIDTH-1:0] last_q;
  logic [HOST_INDEX_WIDTH-1:0] last_d;

  logic                        sel_valid;
  logic [HOST_INDEX_WIDTH-1:0] sel_idx;
  logic [HOSTS-1:0]            sel_grant;
  logic [1:0]                  sel_access;
  logic [ADDRESS_WIDTH-1:0]    sel_address;
  logic [BUS_WIDTH-1:0]        sel_write_data;
  logic [BUS_WIDTH-1:0]        sel_strobe;

  logic                        valid_d;
  logic [1:0]                  access_d;
  logic [ADDRESS_WIDTH-1:0]    address_d;
  logic [BUS_WIDTH-1:0]        write_data_d;
  logic [BUS_WIDTH-1:0]        strobe_d;
  logic [HOSTS-1:0]            host_ready_d;
  logic [1:0]                  host_status_d;
  logic [BUS_WIDTH-1:0]        host_read_data_d;
  logic [HOSTS-1:0]            grant_d;

  // Rotating priority: lowest valid index above last wins, else lowest valid overall.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int j = int'(HOSTS) - 1; j >= 0; j--) begin
      if (i_host_valid[j]) begin
        sel_valid = 1'b1;
        sel_idx   = HOST_INDEX_WIDTH'(j);
      end
    end
    for (int j = int'(HOSTS) - 1; j >= 0; j--) begin
      if (i_host_valid[j] && (HOST_INDEX_WIDTH'(j) > last_q)) begin
        sel_idx = HOST_INDEX_WIDTH'(j);
      end
    end
  end

  // Mux the selected host's request fields.
  always_comb begin
    sel_grant      = '0;
    sel_access     = '0;
    sel_address    = '0;
    sel_write_data = '0;
    sel_strobe     = '0;
    for (int j = 0; j < int'(HOSTS); j++) begin
      if (HOST_INDEX_WIDTH'(j) == sel_idx) begin
        sel_grant[j]   = 1'b1;
        sel_access     = i_host_access[j*2+:2];
        sel_address    = i_host_address[j*ADDRESS_WIDTH+:ADDRESS_WIDTH];
        sel_write_data = i_host_write_data[j*BUS_WIDTH+:BUS_WIDTH];
        sel_strobe     = i_host_strobe[j*BUS_WIDTH+:BUS_WIDTH];
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    last_d           = last_q;
    valid_d          = o_valid;
    access_d         = o_access;
    address_d        = o_address;
    write_data_d     = o_write_data;
    strobe_d         = o_strobe;
    host_ready_d     = '0;
    host_status_d    = o_host_status;
    host_read_data_d = o_host_read_data;
    grant_d          = o_grant;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          state_d      = REQ;
          last_d       = sel_idx;
          valid_d      = 1'b1;
          access_d     = sel_access;
          address_d    = sel_address;
          write_data_d = sel_write_data;
          strobe_d     = sel_strobe;
          grant_d      = sel_grant;
        end
      end
      REQ: begin
        if (i_ready) begin
          state_d          = RESP;
          valid_d          = 1'b0;
          host_ready_d     = o_grant;
          host_status_d    = i_status;
          host_read_data_d = i_read_data;
        end
      end
      RESP: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q          <= IDLE;
      last_q           <= HOST_INDEX_WIDTH'(HOSTS - 1);
      o_valid          <= 1'b0;
      o_access         <= '0;
      o_address        <= '0;
      o_write_data     <= '0;
      o_strobe         <= '0;
      o_host_ready     <= '0;
      o_host_status    <= '0;
      o_host_read_data <= '0;
      o_grant          <= '0;
    end else begin
      state_q          <= state_d;
      last_q           <= last_d;
      o_valid          <= valid_d;
      o_access         <= access_d;
      o_address        <= address_d;
      o_write_data     <= write_data_d;
      o_strobe         <= strobe_d;
      o_host_ready     <= host_ready_d;
      o_host_status    <= host_status_d;
      o_host_read_data <= host_read_data_d;
      o_grant          <= grant_d;
    end
  end

endmodule

// File: tb/tb_rggen_register_access_arbiter.sv
// Bench for rggen_register_access_arbiter: directed scenarios plus randomized traffic
// checked against a round-robin transaction model.
module tb_rggen_register_access_arbiter;

  localparam int unsigned HOSTS = 4;
  localparam int unsigned AW    = 8;
  localparam int unsigned BW    = 32;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [HOSTS-1:0]  i_host_valid;
  logic [HOSTS*2-1:0]  i_host_access;
  logic [HOSTS*AW-1:0] i_host_address;
  logic [HOSTS*BW-1:0] i_host_write_data;
  logic [HOSTS*BW-1:0] i_host_strobe;
  logic [HOSTS-1:0]  o_host_ready;
  logic [1:0]        o_host_status;
  logic [BW-1:0]     o_host_read_data;
  logic              o_valid;
  logic [1:0]        o_access;
  logic [AW-1:0]     o_address;
  logic [BW-1:0]     o_write_data;
  logic [BW-1:0]     o_strobe;
  logic              i_ready;
  logic [1:0]        i_status;
  logic [BW-1:0]     i_read_data;
  logic [HOSTS-1:0]  o_grant;

  // Per-host request contents as the hosts see them.
  logic [1:0]    acc_m [HOSTS];
  logic [AW-1:0] addr_m[HOSTS];
  logic [BW-1:0] wd_m  [HOSTS];
  logic [BW-1:0] sb_m  [HOSTS];

  int            last_m;
  logic [1:0]    st_m;
  logic [BW-1:0] rd_m;
  int            n_vec = 0;
  int            n_err = 0;

  rggen_register_access_arbiter #(
    .HOSTS(HOSTS), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_host_valid(i_host_valid), .i_host_access(i_host_access),
    .i_host_address(i_host_address), .i_host_write_data(i_host_write_data),
    .i_host_strobe(i_host_strobe), .o_host_ready(o_host_ready),
    .o_host_status(o_host_status), .o_host_read_data(o_host_read_data),
    .o_valid(o_valid), .o_access(o_access), .o_address(o_address),
    .o_write_data(o_write_data), .o_strobe(o_strobe),
    .i_ready(i_ready), .i_status(i_status), .i_read_data(i_read_data),
    .o_grant(o_grant)
  );

  always #5 i_clk = ~i_clk;

  always_comb begin
    for (int i = 0; i < int'(HOSTS); i++) begin
      i_host_access[i*2+:2]      = acc_m[i];
      i_host_address[i*AW+:AW]   = addr_m[i];
      i_host_write_data[i*BW+:BW] = wd_m[i];
      i_host_strobe[i*BW+:BW]    = sb_m[i];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Next owner: first valid host scanning last+1, last+2, ... modulo HOSTS.
  function automatic int pick(input logic [HOSTS-1:0] v, input int last);
    for (int k = 1; k <= int'(HOSTS); k++) begin
      int h = (last + k) % int'(HOSTS);
      if (v[h]) return h;
    end
    return -1;
  endfunction

  function automatic logic [HOSTS-1:0] onehot(input int h);
    logic [HOSTS-1:0] g = '0;
    g[h] = 1'b1;
    return g;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 64'(o_valid), 64'(0));
    chk({tag, "_grant"}, 64'(o_grant), 64'(0));
    chk({tag, "_ready"}, 64'(o_host_ready), 64'(0));
    chk({tag, "_status"}, 64'(o_host_status), 64'(st_m));
    chk({tag, "_rdata"}, 64'(o_host_read_data), 64'(rd_m));
  endtask

  // Called at the negedge of the IDLE cycle in which the host valids are sampled.
  task automatic run_access(input int dly, input logic [1:0] st, input logic [BW-1:0] rd,
                            input bit drop, input bit keep);
    int h;
    logic [HOSTS-1:0] g;
    h = pick(i_host_valid, last_m);
    if (h < 0) begin
      $display("FAIL run_access no_requester valid=%b", i_host_valid);
      $fatal(1);
    end
    last_m = h;
    g = onehot(h);
    for (int c = 0; c <= dly; c++) begin
      @(negedge i_clk);
      chk("req_valid", 64'(o_valid), 64'(1));
      chk("req_grant", 64'(o_grant), 64'(g));
      chk("req_access", 64'(o_access), 64'(acc_m[h]));
      chk("req_address", 64'(o_address), 64'(addr_m[h]));
      chk("req_wdata", 64'(o_write_data), 64'(wd_m[h]));
      chk("req_strobe", 64'(o_strobe), 64'(sb_m[h]));
      chk("req_no_ready", 64'(o_host_ready), 64'(0));
      if (c == 0 && drop) i_host_valid[h] = 1'b0;
      if (c == dly) begin
        i_ready = 1'b1; i_status = st; i_read_data = rd;
      end
    end
    @(negedge i_clk);
    st_m = st;
    rd_m = rd;
    chk("resp_ready", 64'(o_host_ready), 64'(g));
    chk("resp_status", 64'(o_host_status), 64'(st));
    chk("resp_rdata", 64'(o_host_read_data), 64'(rd));
    chk("resp_valid", 64'(o_valid), 64'(0));
    chk("resp_grant", 64'(o_grant), 64'(g));
    if (!keep) i_host_valid[h] = 1'b0;
    // i_ready stays high through the response cycle; it must be ignored there.
    @(negedge i_clk);
    i_ready = 1'b0;
    chk_idle("post");
  endtask

  initial begin
    i_rst = 1'b1; i_host_valid = '0; i_ready = 1'b0; i_status = '0; i_read_data = '0;
    for (int i = 0; i < int'(HOSTS); i++) begin
      acc_m[i] = 2'b10; addr_m[i] = '0; wd_m[i] = '0; sb_m[i] = '0;
    end
    last_m = int'(HOSTS) - 1; st_m = '0; rd_m = '0;
    repeat (2) @(negedge i_clk);
    chk_idle("reset");
    chk("reset_access", 64'(o_access), 64'(0));
    chk("reset_address", 64'(o_address), 64'(0));
    chk("reset_wdata", 64'(o_write_data), 64'(0));
    chk("reset_strobe", 64'(o_strobe), 64'(0));
    i_rst = 1'b0;
    @(negedge i_clk);

    // Host 0 write, i_ready two cycles after o_valid.
    acc_m[0] = 2'b11; addr_m[0] = 8'h10; wd_m[0] = 32'hDEADBEEF; sb_m[0] = 32'hFFFFFFFF;
    i_host_valid = 4'b0001;
    run_access(2, 2'b00, $urandom, 1'b0, 1'b0);

    // Hosts 0 and 1 continuously valid, immediate i_ready: grants alternate.
    acc_m[1] = 2'b10; addr_m[1] = 8'h24; wd_m[1] = 32'h0; sb_m[1] = 32'h0;
    i_host_valid = 4'b0011;
    repeat (4) run_access(0, 2'b00, $urandom, 1'b0, 1'b1);
    i_host_valid = '0;

    // i_ready while idle has no effect.
    i_ready = 1'b1;
    repeat (2) @(negedge i_clk);
    i_ready = 1'b0;
    chk_idle("idle_ready");

    // Hosts 1 and 3: pointer wraps from 3 back to 1.
    acc_m[3] = 2'b11; addr_m[3] = 8'hF0; wd_m[3] = 32'h5A5A5A5A; sb_m[3] = 32'h0000FFFF;
    i_host_valid = 4'b1010;
    repeat (3) run_access(1, 2'b00, $urandom, 1'b0, 1'b1);
    i_host_valid = '0;
    @(negedge i_clk);

    // Read answered with slave error.
    i_host_valid = 4'b0010;
    run_access(0, 2'b10, 32'h00001234, 1'b0, 1'b0);

    // Granted host drops valid during the request.
    acc_m[2] = 2'b11; addr_m[2] = 8'h3C; wd_m[2] = 32'hCAFEF00D; sb_m[2] = 32'hFF00FF00;
    i_host_valid = 4'b0100;
    run_access(2, 2'b01, $urandom, 1'b1, 1'b0);

    // Reset during the request abandons the access; host 0 wins afterwards.
    i_host_valid = 4'b0100;
    @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    chk("rst_valid", 64'(o_valid), 64'(0));
    chk("rst_grant", 64'(o_grant), 64'(0));
    chk("rst_ready", 64'(o_host_ready), 64'(0));
    @(negedge i_clk);
    i_rst = 1'b0;
    last_m = int'(HOSTS) - 1; st_m = '0; rd_m = '0;
    chk_idle("rst_release");
    i_host_valid = 4'b1111;
    run_access(1, 2'b00, $urandom, 1'b0, 1'b0);
    i_host_valid = '0;

    // Randomized traffic; hosts only change fields while not requesting.
    for (int n = 0; n < 60; n++) begin
      for (int h = 0; h < int'(HOSTS); h++) begin
        if (!i_host_valid[h]) begin
          acc_m[h]  = ($urandom_range(1, 0) == 1) ? 2'b11 : 2'b10;
          addr_m[h] = AW'($urandom);
          wd_m[h]   = $urandom;
          sb_m[h]   = $urandom;
          i_host_valid[h] = 1'($urandom_range(1, 0));
        end
      end
      if (i_host_valid == '0) i_host_valid[2'($urandom_range(3, 0))] = 1'b1;
      run_access(int'($urandom_range(3, 0)), 2'($urandom), $urandom,
                 $urandom_range(7, 0) == 0, $urandom_range(3, 0) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
